// File: rtl/good_mux_pkg.sv
// Shared defaults and types for the good_mux_sync select-accounting mux.
package good_mux_pkg;
  localparam int WIDTH_DEF = 1;
  localparam int CNT_W_DEF = 8;

  typedef logic [CNT_W_DEF-1:0] cnt_t;
endpackage

// File: rtl/good_mux_sync_if.sv
// Data/select bundle of good_mux_sync; master drives the inputs, slave is the mux.
interface good_mux_sync_if #(
  parameter int WIDTH = good_mux_pkg::WIDTH_DEF,
  parameter int CNT_W = good_mux_pkg::CNT_W_DEF
);
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic             sel;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             sel_chg;
  logic [CNT_W-1:0] sw_cnt;

  modport master (output i0, i1, sel, input y, y_q, sel_chg, sw_cnt);
  modport slave  (input i0, i1, sel, output y, y_q, sel_chg, sw_cnt);
endinterface

// File: rtl/good_mux_sync2.sv
// Two-flop reset-to-0 synchronizer for the select line.
module good_mux_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic s1_d, s1_q, s2_d, s2_q;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;
endmodule

// File: rtl/good_mux_sync.sv
// 2:1 mux with combinational and registered outputs plus select-change pulse/counter.
// Define GOOD_MUX_SEL_SYNC_EN to pass sel through a 2-flop synchronizer for the clocked paths.
module good_mux_sync
  import good_mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic            clk,
  input logic            rst_n,
  good_mux_sync_if.slave bus
);
  logic             sel_s;
  logic [WIDTH-1:0] y_q_d, y_q_q;
  logic             sel_d_d, sel_d_q;
  logic             chg_d, chg_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

`ifdef GOOD_MUX_SEL_SYNC_EN
  good_mux_sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(bus.sel), .q(sel_s));
`else
  assign sel_s = bus.sel;
`endif

  // y uses the raw select so it stays live through reset and ignores the synchronizer.
  assign bus.y = bus.sel ? bus.i1 : bus.i0;

  always_comb begin
    y_q_d   = sel_s ? bus.i1 : bus.i0;
    sel_d_d = sel_s;
    chg_d   = sel_s ^ sel_d_q;
    cnt_d   = cnt_q + CNT_W'(chg_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q_q   <= '0;
      sel_d_q <= 1'b0;
      chg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      y_q_q   <= y_q_d;
      sel_d_q <= sel_d_d;
      chg_q   <= chg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.y_q     = y_q_q;
  assign bus.sel_chg = chg_q;
  assign bus.sw_cnt  = cnt_q;
endmodule

// File: tb/tb_good_mux_sync.sv
// Scoreboard bench for good_mux_sync: an 8-bit-counter instance and a 2-bit-counter instance share stimulus.
module tb_good_mux_sync;
  import good_mux_pkg::*;

`ifdef GOOD_MUX_SEL_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic yq;
    logic chg;
    cnt_t cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  good_mux_sync_if #(.WIDTH(1), .CNT_W(8)) bus_a ();
  good_mux_sync_if #(.WIDTH(1), .CNT_W(2)) bus_b ();

  good_mux_sync #(.WIDTH(1), .CNT_W(8)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  good_mux_sync #(.WIDTH(1), .CNT_W(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  exp_t q[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, phase = 0, pulses = 0;
  int   first_yq = -1, first_chg = -1, drv = 0;

  logic m_s1 = 0, m_s2 = 0, m_seld = 0, m_yq = 0, m_chg = 0;
  cnt_t m_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive at negedge, check y, push the post-edge expectation.
  task automatic step(input logic r, input logic s, input logic a, input logic b);
    logic ss;
    @(negedge clk);
    rst_n = r;
    bus_a.sel = s; bus_a.i0 = a; bus_a.i1 = b;
    bus_b.sel = s; bus_b.i0 = a; bus_b.i1 = b;
    #1;
    chk("y_a", bus_a.y, s ? b : a);
    chk("y_b", bus_b.y, s ? b : a);
    if (!r) begin
      m_s1 = 0; m_s2 = 0; m_seld = 0; m_yq = 0; m_chg = 0; m_cnt = '0;
    end else begin
`ifdef GOOD_MUX_SEL_SYNC_EN
      ss = m_s2; m_s2 = m_s1; m_s1 = s;
`else
      ss = s;
`endif
      m_yq  = ss ? b : a;
      m_chg = (ss != m_seld);
      if (m_chg) m_cnt++;
      m_seld = ss;
    end
    q.push_back('{yq: m_yq, chg: m_chg, cnt: m_cnt});
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    cyc++;
    if (phase == 3 && bus_a.sel_chg) pulses++;
    if (phase == 6 && bus_a.y_q == 1'b1 && first_yq < 0) first_yq = cyc;
    if (phase == 6 && bus_a.sel_chg && first_chg < 0) first_chg = cyc;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("y_q_a", bus_a.y_q, e.yq);
      chk("sel_chg_a", bus_a.sel_chg, e.chg);
      chk("sw_cnt_a", bus_a.sw_cnt, e.cnt);
      chk("y_q_b", bus_b.y_q, e.yq);
      chk("sel_chg_b", bus_b.sel_chg, e.chg);
      chk("sw_cnt_b", bus_b.sw_cnt, e.cnt[1:0]);
    end
  end

  initial begin
    bus_a.sel = 0; bus_a.i0 = 0; bus_a.i1 = 0;
    bus_b.sel = 0; bus_b.i0 = 0; bus_b.i1 = 0;

    // Reset hold: y live, registered outputs zero.
    phase = 1;
    repeat (3) step(0, 1, 0, 1);
    chk("rst_y", bus_a.y, 1);
    chk("rst_cnt", bus_a.sw_cnt, 0);

    // Truth table over {sel, i0, i1}, then flush.
    phase = 2;
    for (int v = 0; v < 8; v++) step(1, v[2], v[1], v[0]);
    repeat (3) step(1, 0, 0, 0);

    // Free-run: sel every 75 ns, i0 every 10 ns, i1 every 55 ns, 300 ns.
    step(0, 0, 0, 0);
    phase = 3; pulses = 0;
    for (int k = 0; k < 30; k++)
      step(1, ((k * 10 / 75) % 2) != 0, (k % 2) != 0, ((k * 10 / 55) % 2) != 0);
    repeat (3) step(1, 1, 0, 0);
    @(posedge clk); #3;
    chk("free_cnt", bus_a.sw_cnt, 3);
    chk("free_pulses", pulses, 3);

    // Wrap on the 2-bit counter: toggle every cycle for 5 cycles.
    phase = 4;
    step(0, 0, 0, 0);
    for (int j = 0; j < 5; j++) step(1, (j % 2) == 0, 0, 1);
    repeat (2) step(1, 1, 0, 1);
    @(posedge clk); #3;
    chk("wrap_cnt_b", bus_b.sw_cnt, 1);
    chk("wrap_cnt_a", bus_a.sw_cnt, 5);
    chk("pre_rst_yq", bus_a.y_q, 1);

    // Async reset between edges with sw_cnt = 5.
    phase = 5;
    rst_n = 0;
    #1;
    chk("async_cnt", bus_a.sw_cnt, 0);
    chk("async_yq", bus_a.y_q, 0);
    chk("async_chg", bus_a.sel_chg, 0);
    chk("async_y", bus_a.y, 1);
    step(0, 0, 0, 1);

    // Select-edge latency to y_q and sel_chg.
    phase = 6;
    repeat (3) step(1, 0, 0, 1);
    step(1, 1, 0, 1);
    drv = cyc;
    repeat (5) step(1, 1, 0, 1);
    @(posedge clk); #3;
    chk("lat_yq", first_yq - drv, LAT);
    chk("lat_chg", first_chg - drv, LAT);
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
